// File: rtl/pio_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// pio_arb_pkg
// Shared types and constants for the PIO read arbiter:
//   state_e      - arbiter FSM states (IDLE, WAIT, RESP)
//   req_idx_t    - index of one of the two requesters
//   wait_cnt_t   - wait-state counter, wide enough for the largest latency
// ---------------------------------------------------------------------------
package pio_arb_pkg;

    localparam int MAX_READ_LATENCY = 4;
    localparam int WAIT_CNT_W       = $clog2(MAX_READ_LATENCY);

    // Explicit encodings keep the state register readable on a bus probe.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef logic                  req_idx_t;
    typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

endpackage

// File: rtl/pio_read_arbiter_if.sv
// ---------------------------------------------------------------------------
// pio_read_arbiter_if
// Bundles both requester-side Avalon-MM read ports, the PIO s1 read port and
// the debug outputs of the arbiter.
//   slave  modport : the arbiter's view (reads requests and PIO data,
//                    drives waitrequest/readdata, PIO address, debug)
//   master modport : the environment's view (requesters + PIO)
// ---------------------------------------------------------------------------
interface pio_read_arbiter_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              r0_read;
    logic [ADDR_W-1:0] r0_address;
    logic              r0_waitrequest;
    logic [DATA_W-1:0] r0_readdata;

    logic              r1_read;
    logic [ADDR_W-1:0] r1_address;
    logic              r1_waitrequest;
    logic [DATA_W-1:0] r1_readdata;

    logic [ADDR_W-1:0] pio_address;
    logic [DATA_W-1:0] pio_readdata;

    logic              grant;
    logic              busy;

    modport slave (
        input  r0_read, r0_address, r1_read, r1_address, pio_readdata,
        output r0_waitrequest, r0_readdata, r1_waitrequest, r1_readdata,
        output pio_address, grant, busy
    );

    modport master (
        output r0_read, r0_address, r1_read, r1_address, pio_readdata,
        input  r0_waitrequest, r0_readdata, r1_waitrequest, r1_readdata,
        input  pio_address, grant, busy
    );
endinterface

// File: rtl/pio_read_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
//   req_i[1:0]    in  : request lines, bit i = requester i
//   last_grant_i  in  : requester served most recently
//   valid_o       out : at least one request present
//   winner_o      out : selected requester (meaningful when valid_o)
// On a tie the requester that was not served last wins.
// ---------------------------------------------------------------------------
module rr_pick2
    import pio_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  req_idx_t   last_grant_i,
    output logic       valid_o,
    output req_idx_t   winner_o
);
    assign valid_o  = |req_i;
    // Single request: bit 1 alone selects requester 1, bit 0 alone selects 0.
    assign winner_o = (req_i == 2'b11) ? ~last_grant_i : req_i[1];
endmodule

// File: rtl/pio_read_arbiter.sv
// ---------------------------------------------------------------------------
// pio_read_arbiter
// Shares one read-only PIO slave between two Avalon-MM requesters with
// round-robin arbitration and a single outstanding read.
//   clk    in  : system clock
//   reset  in  : synchronous, active-high
//   bus    slave modport of pio_read_arbiter_if:
//          rN_read/rN_address in, rN_waitrequest/rN_readdata out,
//          pio_address out, pio_readdata in, grant/busy debug out
// A read seen in IDLE is answered READ_LATENCY+1 cycles later; the RESP
// cycle is the only cycle the owner sees waitrequest low.
// ---------------------------------------------------------------------------
module pio_read_arbiter
    import pio_arb_pkg::*;
#(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic               clk,
    input  logic               reset,
    pio_read_arbiter_if.slave  bus
);
    state_e            state_q, state_d;
    req_idx_t          grant_q, grant_d;
    req_idx_t          last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] pio_address_q, pio_address_d;
    wait_cnt_t         wait_cnt_q, wait_cnt_d;

    logic              pick_valid;
    req_idx_t          pick_winner;

    rr_pick2 u_pick (
        .req_i        ({bus.r1_read, bus.r0_read}),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pio_address_d = pio_address_q;
        wait_cnt_d    = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d       = pick_winner;
                    pio_address_d = pick_winner ? bus.r1_address : bus.r0_address;
                    wait_cnt_d    = wait_cnt_t'(READ_LATENCY - 1);
                    state_d       = WAIT;
                end
            end
            WAIT: begin
                // Address stays latched; requester-side changes are ignored.
                if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - wait_cnt_t'(1);
                end
            end
            RESP: begin
                // Completes even if the requester dropped its read.
                last_grant_d = grant_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            last_grant_q  <= 1'b1;   // requester 0 wins the first tie
            pio_address_q <= '0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            last_grant_q  <= last_grant_d;
            pio_address_q <= pio_address_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    logic resp0, resp1;
    assign resp0 = (state_q == RESP) && (grant_q == 1'b0);
    assign resp1 = (state_q == RESP) && (grant_q == 1'b1);

    assign bus.r0_waitrequest = ~resp0;
    assign bus.r1_waitrequest = ~resp1;
    assign bus.r0_readdata    = resp0 ? bus.pio_readdata : '0;
    assign bus.r1_readdata    = resp1 ? bus.pio_readdata : '0;
    assign bus.pio_address    = pio_address_q;
    assign bus.grant          = grant_q;
    assign bus.busy           = (state_q != IDLE);
endmodule

// File: tb/tb_pio_read_arbiter.sv
module tb_pio_read_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    int   n_tests = 0;
    int   n_fail  = 0;

    pio_read_arbiter_if #(.ADDR_W(2), .DATA_W(32)) ifc1 ();
    pio_read_arbiter_if #(.ADDR_W(2), .DATA_W(32)) ifc3 ();

    pio_read_arbiter #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(rst1), .bus(ifc1));
    pio_read_arbiter #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(rst3), .bus(ifc3));

    typedef struct {
        logic        rst;
        logic        r0r;
        logic [1:0]  r0a;
        logic        r1r;
        logic [1:0]  r1a;
        logic [31:0] pio;
        logic        e_w0;
        logic [31:0] e_d0;
        logic        e_w1;
        logic [31:0] e_d1;
        logic [1:0]  e_pa;
        logic        e_g;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic r0r, logic [1:0] r0a,
                                logic r1r, logic [1:0] r1a, logic [31:0] pio,
                                logic w0, logic [31:0] d0, logic w1, logic [31:0] d1,
                                logic [1:0] pa, logic g, logic b);
        vec_t v;
        v.rst = rst; v.r0r = r0r; v.r0a = r0a; v.r1r = r1r; v.r1a = r1a; v.pio = pio;
        v.e_w0 = w0; v.e_d0 = d0; v.e_w1 = w1; v.e_d1 = d1;
        v.e_pa = pa; v.e_g = g; v.e_busy = b;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        // Idle inputs, reset both instances for two edges.
        rst1 = 1'b1; rst3 = 1'b1;
        ifc1.r0_read = 0; ifc1.r0_address = 0; ifc1.r1_read = 0; ifc1.r1_address = 0;
        ifc1.pio_readdata = 0;
        ifc3.r0_read = 0; ifc3.r0_address = 0; ifc3.r1_read = 0; ifc3.r1_address = 0;
        ifc3.pio_readdata = 0;
        repeat (2) @(posedge clk);

        //            rst r0r r0a r1r r1a pio     w0 d0     w1 d1     pa g busy
        // reset state
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h00, 1, 0,     1, 0,     0, 0, 0));
        // single r0 read, address change after grant ignored
        tbl.push_back(mk(0, 1, 0, 0, 0, 32'hA5, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 32'hA5, 1, 0,     1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 1, 3, 0, 0, 32'hA5, 0, 32'hA5,1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'hA5, 1, 0,     1, 0,     0, 0, 0));
        // r1 read address 1, PIO returns 0
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h00, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h00, 1, 0,     1, 0,     1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 32'h00, 1, 0,     0, 0,     1, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h00, 1, 0,     1, 0,     1, 1, 0));
        // reset, then continuous contention: r0 @0, r1 @2
        tbl.push_back(mk(1, 0, 0, 0, 0, 32'h00, 1, 0,     1, 0,     1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h11, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h11, 1, 0,     1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h11, 0, 32'h11,1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h22, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h22, 1, 0,     1, 0,     2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h22, 1, 0,     0, 32'h22,2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h33, 1, 0,     1, 0,     2, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h33, 1, 0,     1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h33, 0, 32'h33,1, 0,     0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h44, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h44, 1, 0,     1, 0,     2, 1, 1));
        tbl.push_back(mk(0, 1, 0, 1, 2, 32'h44, 1, 0,     0, 32'h44,2, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h44, 1, 0,     1, 0,     2, 1, 0));
        // reset during WAIT aborts, then a fresh r0 read completes
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h55, 1, 0,     1, 0,     2, 1, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 32'h55, 1, 0,     1, 0,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h55, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 32'h66, 1, 0,     1, 0,     0, 0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 32'h66, 1, 0,     1, 0,     2, 0, 1));
        tbl.push_back(mk(0, 1, 2, 0, 0, 32'h66, 0, 32'h66,1, 0,     2, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h66, 1, 0,     1, 0,     2, 0, 0));
        // single continuous requester served every 3 cycles
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 1, 0,     1, 0,     2, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 1, 0,     1, 0,     1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 0, 32'h77,1, 0,     1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 1, 0,     1, 0,     1, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 1, 0,     1, 0,     1, 0, 1));
        tbl.push_back(mk(0, 1, 1, 0, 0, 32'h77, 0, 32'h77,1, 0,     1, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 32'h77, 1, 0,     1, 0,     1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            rst1              = tbl[i].rst;
            ifc1.r0_read      = tbl[i].r0r;
            ifc1.r0_address   = tbl[i].r0a;
            ifc1.r1_read      = tbl[i].r1r;
            ifc1.r1_address   = tbl[i].r1a;
            ifc1.pio_readdata = tbl[i].pio;
            @(negedge clk);
            chk("r0_waitrequest", i, 32'(ifc1.r0_waitrequest), 32'(tbl[i].e_w0));
            chk("r0_readdata",    i, ifc1.r0_readdata,         tbl[i].e_d0);
            chk("r1_waitrequest", i, 32'(ifc1.r1_waitrequest), 32'(tbl[i].e_w1));
            chk("r1_readdata",    i, ifc1.r1_readdata,         tbl[i].e_d1);
            chk("pio_address",    i, 32'(ifc1.pio_address),    32'(tbl[i].e_pa));
            chk("grant",          i, 32'(ifc1.grant),          32'(tbl[i].e_g));
            chk("busy",           i, 32'(ifc1.busy),           32'(tbl[i].e_busy));
            $display("[TB] lat1 vec %0d: w0=%b d0=%h w1=%b d1=%h pa=%0d g=%b busy=%b",
                     i, ifc1.r0_waitrequest, ifc1.r0_readdata, ifc1.r1_waitrequest,
                     ifc1.r1_readdata, ifc1.pio_address, ifc1.grant, ifc1.busy);
        end

        // READ_LATENCY=3: run 0 holds read, run 1 drops it at cycle 2.
        @(posedge clk); #1;
        rst3 = 1'b0;
        for (int run = 0; run < 2; run++) begin
            logic        exp_w[7];
            logic        exp_b[7];
            logic [31:0] exp_d[7];
            exp_w = '{1, 1, 1, 1, 0, 1, 1};
            exp_b = '{0, 1, 1, 1, 1, 0, 0};
            exp_d = '{0, 0, 0, 0, 32'hFF, 0, 0};
            for (int c = 0; c < 7; c++) begin
                if (c > 0) begin
                    @(posedge clk); #1;
                end
                ifc3.r0_read      = (run == 0) ? (c < 5) : (c < 2);
                ifc3.r0_address   = 2'd0;
                ifc3.pio_readdata = 32'hFF;
                @(negedge clk);
                chk("lat3_r0_waitrequest", run * 10 + c, 32'(ifc3.r0_waitrequest), 32'(exp_w[c]));
                chk("lat3_r0_readdata",    run * 10 + c, ifc3.r0_readdata,         exp_d[c]);
                chk("lat3_busy",           run * 10 + c, 32'(ifc3.busy),           32'(exp_b[c]));
                chk("lat3_r1_waitrequest", run * 10 + c, 32'(ifc3.r1_waitrequest), 32'd1);
                $display("[TB] lat3 run %0d cycle %0d: w0=%b d0=%h busy=%b",
                         run, c, ifc3.r0_waitrequest, ifc3.r0_readdata, ifc3.busy);
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
